// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry circular buffer of {adel, pc, instr}
// that presents its oldest entry to decode, with a single-cycle flush for redirects.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stallD,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [31:0]      push_pc,
  input  logic [31:0]      push_instr,
  input  logic             push_adel,
  output logic             validD,
  output logic [31:0]      pcD,
  output logic [31:0]      instrD,
  output logic             adelD,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic        adel;
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic   full, not_empty;
  logic   push, pop;
  entry_t head;

  // Full/empty come from registered occupancy only; a pop never frees a slot
  // for a push in the same cycle.
  assign full       = (count_q == FULL_COUNT);
  assign not_empty  = (count_q != '0);
  assign push_ready = !full;

  assign push = push_valid & push_ready & !flush;
  assign pop  = not_empty & !stallD & !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; occupancy masks stale contents, and leaving
  // the array unreset lets it map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= '{adel: push_adel, pc: push_pc, instr: push_instr};
    end
  end

  // Empty queue drives zeros so decode sees a NOP (instr 0) with no address error.
  assign head   = not_empty ? mem_q[rd_ptr_q] : '0;
  assign validD = not_empty;
  assign pcD    = head.pc;
  assign instrD = head.instr;
  assign adelD  = head.adel;
  assign count  = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=4): reset, latency, full/refuse, stream with
// wrap, flush and reset mid-stream, and address-error delivery.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst, flush, stallD, push_valid, push_ready, push_adel;
  logic [31:0] push_pc, push_instr;
  logic        validD, adelD;
  logic [31:0] pcD, instrD;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stallD(stallD),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_pc(push_pc), .push_instr(push_instr), .push_adel(push_adel),
    .validD(validD), .pcD(pcD), .instrD(instrD), .adelD(adelD), .count(count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [31:0] pc, input logic adel);
    push_valid = 1'b1;
    push_pc    = pc;
    push_instr = pc ^ 32'h2400_0000;
    push_adel  = adel;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stallD = 1'b0;
    push_valid = 1'b0; push_pc = '0; push_instr = '0; push_adel = 1'b0;
    step(); step();
    rst = 1'b0;

    check("rst_validD", 32'(validD), 32'd0);
    check("rst_pcD", pcD, 32'd0);
    check("rst_instrD", instrD, 32'd0);
    check("rst_adelD", 32'(adelD), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_push_ready", 32'(push_ready), 32'd1);

    // First push: invisible in its own cycle, visible next cycle
    push_valid = 1'b1; push_pc = 32'hBFC0_0000; push_instr = 32'h2408_0001; push_adel = 1'b0;
    check("lat_validD_c1", 32'(validD), 32'd0);
    step();
    push_valid = 1'b0;
    check("lat_validD_c2", 32'(validD), 32'd1);
    check("lat_pcD", pcD, 32'hBFC0_0000);
    check("lat_instrD", instrD, 32'h2408_0001);
    check("lat_count", 32'(count), 32'd1);
    step();
    check("lat_drain", 32'(count), 32'd0);

    // Fill under stall; fifth push refused; head held
    stallD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_push(32'(4 * i), 1'b0);
      step();
    end
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(push_ready), 32'd0);
    drive_push(32'h10, 1'b0);
    step();
    check("refuse_count", 32'(count), 32'd4);
    check("hold_pcD", pcD, 32'h0);
    check("hold_instrD", instrD, 32'h2400_0000);
    check("hold_validD", 32'(validD), 32'd1);

    // Full + pop: push refused this cycle, accepted next
    stallD = 1'b0;
    step();
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_pcD", pcD, 32'h4);
    check("fullpop_ready", 32'(push_ready), 32'd1);
    step();
    push_valid = 1'b0;
    check("order_count", 32'(count), 32'd3);
    check("order_pc8", pcD, 32'h8);
    step();
    check("order_pcC", pcD, 32'hC);
    step();
    check("order_pc10", pcD, 32'h10);
    check("order_instr10", instrD, 32'h2400_0010);
    step();
    check("order_empty", 32'(validD), 32'd0);

    // Continuous push+pop stream of 10 entries
    drive_push(32'h1000, 1'b0);
    step();
    check("stream_first_pc", pcD, 32'h1000);
    check("stream_first_count", 32'(count), 32'd1);
    for (int i = 1; i < 10; i++) begin
      drive_push(32'h1000 + 32'(4 * i), 1'b0);
      step();
      check($sformatf("stream_pc_%0d", i), pcD, 32'h1000 + 32'(4 * i));
      check($sformatf("stream_cnt_%0d", i), 32'(count), 32'd1);
    end
    check("stream_instr_last", instrD, 32'h2400_1024);
    push_valid = 1'b0;
    step();
    check("stream_drain", 32'(count), 32'd0);

    // Flush with 3 entries and a concurrent push
    stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h2000 + 32'(4 * i), 1'b0);
      step();
    end
    check("preflush_count", 32'(count), 32'd3);
    flush = 1'b1; stallD = 1'b0;
    drive_push(32'h3000, 1'b0);
    step();
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_validD", 32'(validD), 32'd0);
    check("flush_instrD", instrD, 32'd0);
    check("flush_pcD", pcD, 32'd0);
    drive_push(32'h4000, 1'b0);
    step();
    push_valid = 1'b0;
    check("postflush_validD", 32'(validD), 32'd1);
    check("postflush_pcD", pcD, 32'h4000);
    check("postflush_count", 32'(count), 32'd1);
    step();
    check("postflush_drain", 32'(count), 32'd0);

    // Reset mid-stream under stall
    stallD = 1'b1;
    drive_push(32'h5000, 1'b0);
    step();
    drive_push(32'h5004, 1'b0);
    step();
    check("prerst_count", 32'(count), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0; push_valid = 1'b0; stallD = 1'b0;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_validD", 32'(validD), 32'd0);

    // Address-error entry followed by a clean one
    drive_push(32'h0000_0002, 1'b1);
    step();
    check("adel_flag", 32'(adelD), 32'd1);
    check("adel_pcD", pcD, 32'h0000_0002);
    drive_push(32'h0000_0008, 1'b0);
    step();
    push_valid = 1'b0;
    check("adel_next_flag", 32'(adelD), 32'd0);
    check("adel_next_pcD", pcD, 32'h0000_0008);
    step();
    check("adel_drain", 32'(count), 32'd0);
    check("adel_empty_flag", 32'(adelD), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the fetch stage and the decode stage of the MIPS pipeline. It buffers fetched {pc, instr, address-error} entries from the I-cache side and presents the oldest entry to the main decoder. Each entry is consumed when the decode stage is not stalled. A single-cycle flush, used on branch redirect or exception, discards all buffered entries.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, 2..16
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries; synchronous, same cycle semantics as rst for queue state
- stallD  in  1  decode stage stalled; head entry must be held
- push_valid  in  1  fetch presents an entry
- push_ready  out  1  queue can accept; equals !full
- push_pc  in  32  PC of fetched instruction
- push_instr  in  32  fetched instruction word
- push_adel  in  1  fetch address error (misaligned PC) for this entry
- validD  out  1  head entry valid for decode
- pcD  out  32  head PC
- instrD  out  32  head instruction
- adelD  out  1  head address-error flag
- count  out  PTR_W+1  number of occupied entries, 0..DEPTH

## Operation
- Storage: DEPTH-entry circular buffer of 65-bit entries {adel, pc, instr}. Read pointer rd_ptr, write pointer wr_ptr, count register; pointers wrap modulo DEPTH.
- push = push_valid & push_ready & !flush. The entry is written at wr_ptr, then wr_ptr+1.
- pop = validD & !stallD & !flush. rd_ptr then advances by 1.
- count_next = count + push - pop. Simultaneous push and pop leaves count unchanged. Both are legal when 0 < count < DEPTH, and when count == DEPTH the pop frees a slot next cycle.
- push_ready = (count != DEPTH). This is a registered-state decode with no same-cycle bypass from pop. When full, a push is refused even if a pop occurs in the same cycle.
- No fall-through. An entry pushed into an empty queue becomes visible on validD in the next cycle.
- Outputs come combinationally from the entry at rd_ptr, masked by occupancy:
  - validD = (count != 0).
  - When count == 0, pcD, instrD and adelD are forced to 0. instrD = 0 is a NOP encoding, so the decoder sees a harmless instruction.
- Entries with adel set are queued and delivered like any other entry. Exception handling is downstream.
- flush: in the next cycle rd_ptr = wr_ptr = 0 and count = 0. A push or pop in the flush cycle has no effect. Storage contents are not cleared.
- rst: identical effect to flush. Storage contents are don't-care.
- rst or flush mid-stream (queue partially full, stallD high or low) always yields an empty queue next cycle. No partial retention.

## Timing
- Reset values: validD=0, pcD=0, instrD=0, adelD=0, count=0, push_ready=1.
- Latency: 1 cycle from an accepted push to validD on an empty queue.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- Hold rule: while stallD=1, pcD, instrD and adelD remain stable and validD stays 1 (absent flush).
- After flush asserts in cycle N:
  - validD=0 in cycle N+1.
  - The first post-flush push is accepted in cycle N+1 and is visible in N+2.
- Wrap-around: pointer overflow from DEPTH-1 to 0 must not disturb FIFO order.

## Test plan
- Reset, then push pc=0xBFC00000 instr=0x24080001 in cycle 1 → validD=0 in cycle 1; in cycle 2 validD=1, pcD=0xBFC00000, instrD=0x24080001, count=1.
- Push 4 entries (pc 0x0,0x4,0x8,0xC) with stallD=1 → count=4, push_ready=0, a 5th push (pc 0x10) is refused, and head stays pc 0x0.
- Full queue, stallD=0 with push_valid=1 for 1 cycle → the pop occurs and the push is refused (count=3). Next cycle the push is accepted, and the pop order is 0x4,0x8,0xC,0x10.
- Stream 10 entries with continuous push and pop, stallD=0 → count stays at 1 after the first cycle, pcD increments by 4 each cycle, and order is preserved across 2 pointer wraps.
- Queue count=3, assert flush together with push_valid=1 and stallD=0 → next cycle count=0, validD=0, instrD=0. The flush-cycle push is lost, and a push one cycle later appears as head.
- Push an entry with push_adel=1, pc=0x00000002 → delivered with adelD=1, pcD=0x00000002, and the following entry has adelD=0.
